// File: rtl/router_pkg.sv
// Shared types and sizing helpers for the multi-port weight router.
package router_pkg;

    typedef enum logic [2:0] {IDLE, REQ, CAPT, SEND, FIN} wr_state_t;
    typedef enum logic {UNICAST, BROADCAST} route_mode_t;

    function automatic int unsigned kernel_words(input int unsigned k);
        return k * k;
    endfunction

    // Index width that stays legal (>=1 bit) for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/router_port_arbiter.sv
// Per-port valid tracking: holds the ports still owed the current word.
module router_port_arbiter #(
    parameter int unsigned NUM_PE_PORTS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [NUM_PE_PORTS-1:0] dest_mask,
    input  logic [NUM_PE_PORTS-1:0] spad_ready,
    output logic [NUM_PE_PORTS-1:0] load_en,
    output logic                    accepted_all_c
);

    // load_en is dest_mask & ~sent_mask kept directly: accepted ports drop out.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_en <= '0;
        end else if (load) begin
            load_en <= dest_mask;
        end else begin
            load_en <= load_en & ~spad_ready;
        end
    end

    assign accepted_all_c = ((load_en & ~spad_ready) == '0);

endmodule

// File: rtl/router_weight_mc.sv
// Streams filter weights from the GLB into several PE spads, unicast or broadcast.
module router_weight_mc
    import router_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH      = 16,
    parameter int unsigned ADDR_BITWIDTH_GLB  = 10,
    parameter int unsigned ADDR_BITWIDTH_SPAD = 9,
    parameter int unsigned NUM_PE_PORTS       = 3,
    parameter int unsigned KERNEL_SIZE        = 3,
    parameter int unsigned MAX_FILTERS        = 8,
    parameter int unsigned W_LOAD_ADDR        = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load_spad_ctrl,
    input  logic                                 mode_bcast,
    input  logic [$clog2(MAX_FILTERS+1)-1:0]     num_filters,
    input  logic [ADDR_BITWIDTH_GLB-1:0]         glb_base_addr,
    output logic                                 read_req_glb_wght,
    output logic [ADDR_BITWIDTH_GLB-1:0]         r_addr_glb_wght,
    input  logic [DATA_BITWIDTH-1:0]             r_data_glb_wght,
    output logic [DATA_BITWIDTH-1:0]             w_data_spad,
    output logic [ADDR_BITWIDTH_SPAD-1:0]        w_addr_spad,
    output logic [NUM_PE_PORTS-1:0]              load_en_spad,
    input  logic [NUM_PE_PORTS-1:0]              spad_ready,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned K2   = kernel_words(KERNEL_SIZE);
    localparam int unsigned NF_W = $clog2(MAX_FILTERS + 1);
    localparam int unsigned K_W  = idx_width(K2);
    localparam int unsigned P_W  = idx_width(NUM_PE_PORTS);

    wr_state_t                   state;
    wr_state_t                   state_n;
    route_mode_t                 mode;
    logic [NF_W-1:0]             nf_q;
    logic [NF_W-1:0]             f_q;
    logic [NF_W-1:0]             slot_q;
    logic [K_W-1:0]              k_q;
    logic [P_W-1:0]              port_q;

    logic [NF_W-1:0]             nf_clamp_c;
    logic [NF_W-1:0]             slot_sel_c;
    logic [ADDR_BITWIDTH_SPAD-1:0] spad_addr_c;
    logic [NUM_PE_PORTS-1:0]     dest_mask_c;
    logic                        last_k_c;
    logic                        last_word_c;
    logic                        word_done_c;

    assign nf_clamp_c  = (num_filters > NF_W'(MAX_FILTERS)) ? NF_W'(MAX_FILTERS) : num_filters;
    assign last_k_c    = (k_q == K_W'(K2 - 1));
    assign last_word_c = last_k_c && (f_q == nf_q - NF_W'(1));
    assign slot_sel_c  = (mode == BROADCAST) ? f_q : slot_q;
    assign spad_addr_c = ADDR_BITWIDTH_SPAD'(W_LOAD_ADDR + 32'(slot_sel_c) * K2 + 32'(k_q));
    assign dest_mask_c = (mode == BROADCAST) ? {NUM_PE_PORTS{1'b1}}
                                             : (NUM_PE_PORTS'(1) << port_q);

    router_port_arbiter #(
        .NUM_PE_PORTS (NUM_PE_PORTS)
    ) u_arbiter (
        .clk            (clk),
        .reset          (reset),
        .load           (state == CAPT),
        .dest_mask      (dest_mask_c),
        .spad_ready     (spad_ready),
        .load_en        (load_en_spad),
        .accepted_all_c (word_done_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (load_spad_ctrl) state_n = (num_filters == '0) ? FIN : REQ;
            REQ:  state_n = CAPT;
            CAPT: state_n = SEND;
            SEND: if (word_done_c) state_n = last_word_c ? FIN : REQ;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes follow the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_req_glb_wght <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            r_addr_glb_wght   <= '0;
            w_data_spad       <= '0;
            w_addr_spad       <= '0;
            mode              <= UNICAST;
            nf_q              <= '0;
            f_q               <= '0;
            slot_q            <= '0;
            k_q               <= '0;
            port_q            <= '0;
        end else begin
            read_req_glb_wght <= (state_n == REQ);
            busy              <= (state_n != IDLE);
            done              <= (state_n == FIN);
            case (state)
                IDLE: begin
                    if (load_spad_ctrl) begin
                        mode            <= route_mode_t'(mode_bcast);
                        nf_q            <= nf_clamp_c;
                        r_addr_glb_wght <= glb_base_addr;
                        f_q             <= '0;
                        slot_q          <= '0;
                        k_q             <= '0;
                        port_q          <= '0;
                    end
                end
                CAPT: begin
                    w_data_spad <= r_data_glb_wght;
                    w_addr_spad <= spad_addr_c;
                end
                SEND: begin
                    // Running GLB address equals base + f*K^2 + k, wrapping naturally.
                    if (word_done_c && !last_word_c) begin
                        r_addr_glb_wght <= r_addr_glb_wght + ADDR_BITWIDTH_GLB'(1);
                        if (last_k_c) begin
                            k_q <= '0;
                            f_q <= f_q + NF_W'(1);
                            if (port_q == P_W'(NUM_PE_PORTS - 1)) begin
                                port_q <= '0;
                                slot_q <= slot_q + NF_W'(1);
                            end else begin
                                port_q <= port_q + P_W'(1);
                            end
                        end else begin
                            k_q <= k_q + K_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
